// File: rtl/ebi_bus_master_if.sv
// rtl/ebi_bus_master_if.sv - request/response and EBI pin bundle for ebi_bus_master
interface ebi_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       ebi_cs_n;
    logic       ebi_we_n;
    logic       ebi_oe_n;
    logic [2:0] ebi_addr;
    logic [7:0] ebi_data_out;
    logic       ebi_data_oe;
    logic [7:0] ebi_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ebi_data_in,
        output req_ready, rsp_valid, rsp_rdata,
        output ebi_cs_n, ebi_we_n, ebi_oe_n, ebi_addr, ebi_data_out, ebi_data_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ebi_data_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ebi_cs_n, ebi_we_n, ebi_oe_n, ebi_addr, ebi_data_out, ebi_data_oe
    );
endinterface

// File: rtl/ebi_bus_master.sv
// rtl/ebi_bus_master.sv - EBI-style bus initiator with parameterised strobe timing
module ebi_bus_master #(
    parameter int T_AS = 1,
    parameter int T_WP = 2,
    parameter int T_WR = 1,
    parameter int T_RC = 2
) (
    input  logic             clk,
    input  logic             rst,
    ebi_bus_master_if.master bus
);

    if (T_AS < 1 || T_AS > 15 || T_WP < 1 || T_WP > 15 ||
        T_WR < 1 || T_WR > 15 || T_RC < 1 || T_RC > 15) begin : g_param_check
        $fatal(1, "ebi_bus_master: timing parameters must be in 1..15");
    end

    localparam logic [3:0] CNT_AS = 4'(T_AS - 1);
    localparam logic [3:0] CNT_WP = 4'(T_WP - 1);
    localparam logic [3:0] CNT_WR = 4'(T_WR - 1);
    localparam logic [3:0] CNT_RC = 4'(T_RC - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_RECOV,
        R_STROBE
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       accept;

    logic       cs_n_q, we_n_q, oe_n_q, data_oe_q, rsp_valid_q;
    logic [2:0] addr_q;
    logic [7:0] wdata_q, rdata_q;

    logic       cs_n_next, we_n_next, oe_n_next, data_oe_next, rsp_valid_next;
    logic [2:0] addr_next;
    logic [7:0] wdata_next, rdata_next;

    assign bus.req_ready    = (state == IDLE) && !rst;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.ebi_cs_n     = cs_n_q;
    assign bus.ebi_we_n     = we_n_q;
    assign bus.ebi_oe_n     = oe_n_q;
    assign bus.ebi_addr     = addr_q;
    assign bus.ebi_data_out = wdata_q;
    assign bus.ebi_data_oe  = data_oe_q;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        addr_next      = addr_q;
        wdata_next     = wdata_q;
        rdata_next     = rdata_q;
        rsp_valid_next = 1'b0;
        accept         = bus.req_valid && bus.req_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    addr_next  = bus.req_addr;
                    wdata_next = bus.req_wdata;
                    if (bus.req_write) begin
                        state_next = W_SETUP;
                        cnt_next   = CNT_AS;
                    end else begin
                        state_next = R_STROBE;
                        cnt_next   = CNT_RC;
                    end
                end
            end
            W_SETUP: begin
                if (cnt == 4'd0) begin
                    state_next = W_PULSE;
                    cnt_next   = CNT_WP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            W_PULSE: begin
                if (cnt == 4'd0) begin
                    state_next = W_RECOV;
                    cnt_next   = CNT_WR;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            W_RECOV: begin
                if (cnt == 4'd0) begin
                    state_next     = IDLE;
                    cnt_next       = 4'd0;
                    rsp_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            R_STROBE: begin
                // Only the last strobe cycle's bus value is captured; earlier cycles may still be settling.
                if (cnt == 4'd0) begin
                    state_next     = IDLE;
                    cnt_next       = 4'd0;
                    rsp_valid_next = 1'b1;
                    rdata_next     = bus.ebi_data_in;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        // Strobes are decoded from the next state so the pins change on the same edge as the state.
        cs_n_next    = (state_next == IDLE);
        we_n_next    = (state_next != W_PULSE);
        oe_n_next    = (state_next != R_STROBE);
        data_oe_next = (state_next == W_PULSE) || (state_next == W_RECOV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= 3'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cs_n_q      <= cs_n_next;
            we_n_q      <= we_n_next;
            oe_n_q      <= oe_n_next;
            data_oe_q   <= data_oe_next;
            rsp_valid_q <= rsp_valid_next;
            addr_q      <= addr_next;
            wdata_q     <= wdata_next;
            rdata_q     <= rdata_next;
        end
    end

endmodule

// File: tb/tb_ebi_bus_master.sv
// tb/tb_ebi_bus_master.sv - scoreboard bench for ebi_bus_master with a register-file bus slave
module tb_ebi_bus_master;
    localparam int T_AS = 1;
    localparam int T_WP = 2;
    localparam int T_WR = 1;
    localparam int T_RC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ebi_bus_master_if bus();

    ebi_bus_master #(.T_AS(T_AS), .T_WP(T_WP), .T_WR(T_WR), .T_RC(T_RC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [8];
    logic [7:0] slave_mem [8];
    logic [7:0] last_read;
    logic       split_en;
    logic [7:0] early_val;
    int         n_vec = 0;
    int         n_err = 0;
    int         last_gap = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Peripheral register file on the far side of the bus; early strobe cycles can carry junk.
    initial begin
        int oe_idx;
        oe_idx = 0;
        for (int i = 0; i < 8; i++) slave_mem[i] = 8'(i * 17 + 3);
        bus.ebi_data_in = 8'h00;
        forever begin
            @(posedge clk);
            if (!rst && !bus.ebi_cs_n && !bus.ebi_we_n)
                slave_mem[bus.ebi_addr] = bus.ebi_data_out;
            #1;
            if (!rst && !bus.ebi_oe_n) begin
                if (split_en && oe_idx < T_RC - 1) bus.ebi_data_in = early_val;
                else                               bus.ebi_data_in = slave_mem[bus.ebi_addr];
                oe_idx++;
            end else begin
                oe_idx = 0;
                bus.ebi_data_in = 8'($urandom);
            end
        end
    end

    // Monitor: response scoreboard, bus invariants, idle gap between transactions.
    initial begin
        exp_t e;
        int   hi_run;
        logic prev_cs_n;
        logic seen_low;
        hi_run = 0;
        prev_cs_n = 1'b1;
        seen_low = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_run = 0;
                seen_low = 1'b0;
                prev_cs_n = 1'b1;
            end else begin
                chk("inv_drive_vs_oe", 32'(bus.ebi_data_oe && !bus.ebi_oe_n), 0);
                chk("inv_we_and_oe", 32'(!bus.ebi_we_n && !bus.ebi_oe_n), 0);
                if (bus.ebi_cs_n) begin
                    hi_run++;
                end else begin
                    if (prev_cs_n && seen_low) last_gap = hi_run;
                    hi_run = 0;
                    seen_low = 1'b1;
                end
                prev_cs_n = bus.ebi_cs_n;
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rsp", 32'(bus.rsp_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(e.wr ? "wr_rsp_rdata" : "rd_rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    end
                end
            end
        end
    end

    // Issue one transaction from a negedge and follow its bus cycle until the response cycle.
    task automatic issue(input logic wr, input logic [2:0] a, input logic [7:0] d,
                         input logic busy_en, input logic [2:0] ba, input logic [7:0] bd);
        exp_t e;
        int   total;
        int   tmo;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tmo = 0;
        while (!bus.req_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 1);
            bus.req_valid = 1'b0;
            return;
        end
        e.wr = wr;
        e.addr = a;
        e.wdata = d;
        if (wr) begin
            model_mem[a] = d;
            e.rdata = last_read;
        end else begin
            e.rdata = model_mem[a];
            last_read = model_mem[a];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        total = wr ? (T_AS + T_WP + T_WR) : T_RC;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            chk($sformatf("cs_n[%0d]", k), 32'(bus.ebi_cs_n), (k <= total) ? 0 : 1);
            chk($sformatf("rsp_valid[%0d]", k), 32'(bus.rsp_valid), (k == total + 1) ? 1 : 0);
            if (wr) begin
                chk($sformatf("wr_we_n[%0d]", k), 32'(bus.ebi_we_n), (k > T_AS && k <= T_AS + T_WP) ? 0 : 1);
                chk($sformatf("wr_oe_n[%0d]", k), 32'(bus.ebi_oe_n), 1);
                chk($sformatf("wr_data_oe[%0d]", k), 32'(bus.ebi_data_oe), (k > T_AS && k <= total) ? 1 : 0);
            end else begin
                chk($sformatf("rd_oe_n[%0d]", k), 32'(bus.ebi_oe_n), (k <= total) ? 0 : 1);
                chk($sformatf("rd_we_n[%0d]", k), 32'(bus.ebi_we_n), 1);
                chk($sformatf("rd_data_oe[%0d]", k), 32'(bus.ebi_data_oe), 0);
            end
            if (k <= total) begin
                chk($sformatf("addr[%0d]", k), 32'(bus.ebi_addr), 32'(a));
                chk($sformatf("data_out[%0d]", k), 32'(bus.ebi_data_out), 32'(d));
            end
            if (busy_en && k == T_AS + 1) begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = ba;
                bus.req_wdata = bd;
                chk("busy_req_ready", 32'(bus.req_ready), 0);
            end
        end
    endtask

    initial begin
        int tmo;
        logic wr;
        logic [2:0] a;
        logic [7:0] d;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 3'd0;
        bus.req_wdata = 8'd0;
        split_en  = 1'b0;
        early_val = 8'h00;
        last_read = 8'h00;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'(i * 17 + 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(bus.ebi_cs_n), 1);
        chk("rst_we_n", 32'(bus.ebi_we_n), 1);
        chk("rst_oe_n", 32'(bus.ebi_oe_n), 1);
        chk("rst_addr", 32'(bus.ebi_addr), 0);
        chk("rst_data_out", 32'(bus.ebi_data_out), 0);
        chk("rst_data_oe", 32'(bus.ebi_data_oe), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 1);

        issue(1'b1, 3'd1, 8'h96, 1'b0, 3'd0, 8'h00);
        issue(1'b1, 3'd1, 8'hAE, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 3'd1, 8'h00, 1'b0, 3'd0, 8'h00);

        // Final-cycle capture: junk in the first strobe cycle, register value in the last.
        issue(1'b1, 3'd2, 8'hF0, 1'b0, 3'd0, 8'h00);
        split_en  = 1'b1;
        early_val = 8'h0F;
        issue(1'b0, 3'd2, 8'h00, 1'b0, 3'd0, 8'h00);
        split_en  = 1'b0;

        issue(1'b1, 3'd1, 8'h5F, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        chk("b2b_gap", 32'(last_gap), 1);

        issue(1'b1, 3'd3, 8'h3C, 1'b1, 3'd5, 8'hC3);
        issue(1'b1, 3'd5, 8'hC3, 1'b0, 3'd0, 8'h00);
        issue(1'b0, 3'd3, 8'h00, 1'b0, 3'd0, 8'h00);

        // Reset in the second cycle of a write; data equals current contents so the slave stays in step.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 3'd4;
        bus.req_wdata = model_mem[4];
        tmo = 0;
        while (!bus.req_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        chk("abort_accept", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_rst", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        chk("abort_cs_n", 32'(bus.ebi_cs_n), 1);
        chk("abort_we_n", 32'(bus.ebi_we_n), 1);
        chk("abort_oe_n", 32'(bus.ebi_oe_n), 1);
        chk("abort_data_oe", 32'(bus.ebi_data_oe), 0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("abort_rsp_rdata", 32'(bus.rsp_rdata), 0);
        rst = 1'b0;
        last_read = 8'h00;
        @(negedge clk);
        chk("abort_req_ready", 32'(bus.req_ready), 1);
        repeat (3) @(negedge clk);
        issue(1'b1, 3'd6, 8'h11, 1'b0, 3'd0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            split_en  = !wr && ($urandom_range(0, 1) == 1);
            early_val = 8'($urandom);
            issue(wr, a, d, 1'b0, 3'd0, 8'h00);
            split_en = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("pending_rsp", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
